// File: rtl/shift_left_serializer.sv
// Parallel-in, serial-out transmitter: loads a word on start and shifts it out MSB-first on enable.
// Optional macro SHIFT_PARITY_EN appends an even-parity bit after the data bits.
module shift_left_serializer #(
    parameter int unsigned Word_Length = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   enable,
    input  logic [Word_Length-1:0] Data_Input,
    output logic                   Serial_Out,
    output logic                   Serial_Valid,
    output logic                   Busy,
    output logic                   Done,
    output logic [Word_Length-1:0] Data_Output
);

    localparam int unsigned CNT_W = $clog2(Word_Length + 2);
`ifdef SHIFT_PARITY_EN
    localparam int unsigned NUM_SLOTS = Word_Length + 1;
`else
    localparam int unsigned NUM_SLOTS = Word_Length;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [Word_Length-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sout_q, sout_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
`ifdef SHIFT_PARITY_EN
    logic                   par_q, par_d;
`endif

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHIFT_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SHIFT_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next state, datapath and next-cycle outputs
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef SHIFT_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = Data_Input;
                    cnt_d   = CNT_W'(NUM_SLOTS);
`ifdef SHIFT_PARITY_EN
                    par_d   = ^Data_Input;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (enable) begin
                    shreg_d = {shreg_q[Word_Length-2:0], 1'b0};
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are derived from the next state so they are flop-driven in the cycle they apply
        valid_d = (state_d == SHIFT);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        sout_d  = 1'b0;
        if (state_d == SHIFT) begin
            sout_d = shreg_d[Word_Length-1];
`ifdef SHIFT_PARITY_EN
            // The last slot (count of one) carries the parity bit
            if (cnt_d == CNT_W'(1)) begin
                sout_d = par_d;
            end
`endif
        end
    end

    assign Serial_Out   = sout_q;
    assign Serial_Valid = valid_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Data_Output  = shreg_q;

endmodule

// File: tb/tb_shift_left_serializer.sv
// Scoreboard bench for shift_left_serializer: stimulus queues expected serial bits, a negedge monitor checks them.
module tb_shift_left_serializer;

    localparam int unsigned W = 8;
`ifdef SHIFT_PARITY_EN
    localparam int unsigned NB = W + 1;
`else
    localparam int unsigned NB = W;
`endif
    localparam int DONE_TOK = 2;

    logic         clk;
    logic         reset;
    logic         start;
    logic         enable;
    logic [W-1:0] Data_Input;
    logic         Serial_Out;
    logic         Serial_Valid;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Data_Output;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    shift_left_serializer #(.Word_Length(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .enable       (enable),
        .Data_Input   (Data_Input),
        .Serial_Out   (Serial_Out),
        .Serial_Valid (Serial_Valid),
        .Busy         (Busy),
        .Done         (Done),
        .Data_Output  (Data_Output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: data bits MSB-first, optional even parity, then a single Done.
    task automatic push_word(input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(int'(d[i]));
`ifdef SHIFT_PARITY_EN
        exp_q.push_back($countones(d) % 2);
`endif
        exp_q.push_back(DONE_TOK);
    endtask

    // Monitor: compares each presented bit to the queue head; pops when the bit is consumed.
    always @(negedge clk) begin
        if (!reset) begin
            chk("reset_outputs", {28'd0, Serial_Out, Serial_Valid, Busy, Done}, 32'd0);
            chk("reset_data_output", 32'(Data_Output), 32'd0);
        end else if (Done) begin
            if (exp_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
            else begin
                chk("done_order", 32'(exp_q[0]), 32'(DONE_TOK));
                void'(exp_q.pop_front());
            end
            chk("done_outputs", {29'd0, Serial_Valid, Serial_Out, Busy}, 32'd1);
            chk("done_data_output", 32'(Data_Output), 32'd0);
        end else if (Serial_Valid) begin
            chk("busy_in_shift", 32'(Busy), 32'd1);
            if (exp_q.size() == 0 || exp_q[0] == DONE_TOK) chk("bit_unexpected", 32'd1, 32'd0);
            else begin
                chk("serial_bit", 32'(Serial_Out), 32'(exp_q[0]));
                if (enable) void'(exp_q.pop_front());
            end
        end else begin
            chk("idle_outputs", {30'd0, Busy, Serial_Out}, 32'd0);
        end
    end

    // One transfer: junk 0 none, 1 zero data starts, 2 random data starts; abort_after<0 means no abort.
    task automatic run_word(input logic [W-1:0] d, input bit rnd_en, input int stall_bit,
                            input int junk, input int abort_after);
        int cyc = 0;
        int consumed = 0;
        int stall_cnt = 0;
        start = 1'b1;
        Data_Input = d;
        enable = 1'b0;
        push_word(d);
        @(posedge clk); #1;
        start = 1'b0;
        chk("first_bit_valid", {30'd0, Serial_Valid, Busy}, 32'd3);
        cyc = 1;
        forever begin
            if (abort_after >= 0 && consumed == abort_after) begin
                reset = 1'b0;
                exp_q.delete();
                start = 1'b0;
                enable = 1'b0;
                #1;
                chk("abort_immediate", {27'd0, Serial_Out, Serial_Valid, Busy, Done, |Data_Output}, 32'd0);
                repeat (2) @(posedge clk);
                #1 reset = 1'b1;
                return;
            end
            if (Done) begin
                if (!rnd_en && stall_bit < 0) chk("done_latency", 32'(cyc), 32'(NB + 1));
                start = (junk != 0);
                Data_Input = (junk == 2) ? W'($urandom) : '0;
                enable = 1'(($urandom));
                @(posedge clk); #1;
                start = 1'b0;
                chk("idle_after_done", {30'd0, Busy, Done}, 32'd0);
                return;
            end
            if (cyc > 400) begin
                chk("done_timeout", 32'(cyc), 32'(NB + 1));
                return;
            end
            if (stall_cnt > 0) begin
                enable = 1'b0;
                stall_cnt--;
            end else begin
                enable = rnd_en ? (($urandom % 10) < 7) : 1'b1;
            end
            if (Serial_Valid && enable) begin
                consumed++;
                if (consumed == stall_bit) stall_cnt = 5;
            end
            if (junk != 0) begin
                start = (($urandom % 3) == 0);
                Data_Input = (junk == 2) ? W'($urandom) : '0;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b1;
        enable = 1'b0;
        Data_Input = 8'hFF;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        run_word(8'hFF, 1'b0, -1, 0, -1);
        run_word(8'hA5, 1'b0, -1, 0, -1);
        run_word(8'h81, 1'b0, 2, 0, -1);
        run_word(8'hFF, 1'b0, -1, 1, -1);
        run_word(8'h3C, 1'b0, -1, 0, 4);
        run_word(8'hC3, 1'b0, -1, 0, -1);
        run_word(8'h07, 1'b0, -1, 0, -1);
        run_word(8'h03, 1'b0, -1, 0, -1);
        for (int n = 0; n < 40; n++) begin
            run_word(W'($urandom), 1'b1, -1, 2,
                     (($urandom % 10) == 0) ? int'($urandom % W) : -1);
        end
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
